trace_dump: RTL

Capture-memory readout stage directly downstream of the analog capture/trigger interface. Once capture completes, it walks the 512-entry circular trace RAM of the selected channel in chronological order, starting with the oldest sample (the entry after `trace_end`). It streams each byte to the UART transmitter over a valid/ready handshake. When the last sample is accepted it clears the capture-done flag so the front end re-arms.

---
 rtl/trace_dump.sv | 98 +++++++++
 1 files changed

// File: rtl/trace_dump.sv
// Trace RAM readout: after capture completes, streams DEPTH samples of one channel,
// oldest first, to the UART over valid/ready, then clears the capture-done flag.
module trace_dump #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_start,
  input  logic [1:0]    dump_chan,
  input  logic          cap_done,
  input  logic [AW-1:0] trace_end,
  output logic          ram_en,
  output logic [1:0]    ram_sel,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          dump_done,
  output logic          clr_cap_done,
  output logic          dump_err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ram_en       <= 1'b0;
      ram_sel      <= 2'd0;
      ram_addr     <= '0;
      tx_data      <= 8'd0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      dump_done    <= 1'b0;
      clr_cap_done <= 1'b0;
      dump_err     <= 1'b0;
    end else begin
      ram_en       <= 1'b0;
      dump_done    <= 1'b0;
      clr_cap_done <= 1'b0;
      dump_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            if (cap_done) begin
              // Channel code 3 has no bank of its own and aliases CH1.
              ram_sel  <= (dump_chan == 2'd3) ? 2'd0 : dump_chan;
              ram_addr <= trace_end + ONE;
              cnt      <= '0;
              ram_en   <= 1'b1;
              busy     <= 1'b1;
              state    <= READ;
            end else begin
              dump_err <= 1'b1;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          tx_data  <= ram_rdata;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (cnt == LAST) begin
              dump_done    <= 1'b1;
              clr_cap_done <= 1'b1;
              state        <= DONE;
            end else begin
              cnt      <= cnt + ONE;
              ram_addr <= ram_addr + ONE;
              ram_en   <= 1'b1;
              state    <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
